// File: rtl/ureg_arbiter.sv
// ureg_arbiter: two-master round-robin arbiter for the user register bus.
// m0 (AXI bridge) and m1 (local master) share reg_addr/reg_wdata/reg_wr/
// reg_rd/reg_rdata with one transaction in flight at a time.
// Each access ends with a one-cycle ack to the granted master.
// Optional feature: define UREG_ARB_LOCK_EN to add m0_lock/m1_lock.
// With the lock, a master can hold the bus across several transactions,
// for example for an atomic read-modify-write.
module ureg_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              s_axi_clk,
  input  logic              s_axi_resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef UREG_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;     // 0 = m0, 1 = m1 owns the transaction
  logic              last_q, last_d;   // master granted most recently
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              req0_eff, req1_eff;
  logic              pick;
`ifdef UREG_ARB_LOCK_EN
  logic              lock_q, lock_d;
`endif

  // State and datapath registers; reset aborts any transaction in flight.
  // last_q resets to 1 so that m0 wins the first tie.
  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef UREG_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef UREG_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, strobe in ISSUE, count read latency
  // in WAIT, and acknowledge in ACK.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    req0_eff = m0_req;
    req1_eff = m1_req;
    pick     = 1'b0;
`ifdef UREG_ARB_LOCK_EN
    lock_d   = lock_q;
    // While locked, gnt_q still names the owner, so the other request is masked.
    if (lock_q) begin
      if (gnt_q) req0_eff = 1'b0;
      else       req1_eff = 1'b0;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_eff || req1_eff) begin
          // Tie goes to the master that was not granted last time.
          // A single request is simply granted.
          pick    = (req0_eff && req1_eff) ? ~last_q : req1_eff;
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? m1_we    : m0_we;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (gnt_q) rdata1_d = reg_rdata;
          else       rdata0_d = reg_rdata;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef UREG_ARB_LOCK_EN
        // Only the owner can be granted while locked, so its lock level
        // in ACK both sets and releases the lock.
        lock_d = gnt_q ? m1_lock : m0_lock;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and acks are decoded from the state register.
  // Reset forces them to 0 immediately.
  assign reg_wr    = (state_q == S_ISSUE) &&  we_q;
  assign reg_rd    = (state_q == S_ISSUE) && !we_q;
  assign m0_ack    = (state_q == S_ACK) && !gnt_q;
  assign m1_ack    = (state_q == S_ACK) &&  gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: doc/ureg_arbiter.md
Name: ureg_arbiter

Overview:
- Two-master arbiter for the single user register bus (reg_addr / reg_wdata / reg_wr / reg_rd / reg_rdata) that sits behind the AXI4-Lite bridge.
- Lets the AXI bridge (m0) and a second local master, e.g. a debug UART or an autonomous status poller (m1), share the register file without collisions.
- Round-robin grant, one transaction in flight; each access completes with a single-cycle ack pulse.

Parameters:
ADDR_W, 11, width of register address (word-index bus).
DATA_W, 32, register data width.
RD_LAT, 1, cycles from reg_rd strobe to valid reg_rdata (1..4).

Ports:
s_axi_clk  in  1  clock.
s_axi_resetn  in  1  asynchronous active-low reset.
m0_req  in  1  master 0 request, level, held until m0_ack.
m0_we  in  1  1 = write, 0 = read; valid with m0_req.
m0_addr  in  ADDR_W  register address.
m0_wdata  in  DATA_W  write data.
m0_ack  out  1  one-cycle completion pulse.
m0_rdata  out  DATA_W  read data, valid while m0_ack = 1.
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same directions, widths and meanings as the m0 ports, for master 1.
reg_addr  out  ADDR_W  to register file.
reg_wdata  out  DATA_W  to register file.
reg_wr  out  1  write strobe, one cycle.
reg_rd  out  1  read strobe, one cycle.
reg_rdata  in  DATA_W  from register file, valid RD_LAT cycles after reg_rd.
busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): FSM enters IDLE; last_gnt = 1, so m0 wins the first tie.
- All outputs reset to 0: acks, rdata, reg_addr, reg_wdata, reg_wr, reg_rd, busy.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Samples m0_req and m1_req.
  - One request: grant it.
  - Both requests: grant the master that is not last_gnt, then update last_gnt.
  - Latch the winner's we, addr and wdata into reg_addr / reg_wdata and go to ISSUE.
- ISSUE (1 cycle): reg_wr = 1 if write, else reg_rd = 1.
  - Write goes directly to ACK.
  - Read goes to WAIT.
- WAIT (RD_LAT cycles): counter runs; in the last WAIT cycle reg_rdata is captured into the granted master's rdata register, then go to ACK.
- ACK (1 cycle): granted master's ack = 1; its rdata holds the captured value (reads) or is unchanged (writes); return to IDLE.
- reg_addr and reg_wdata hold their last values between transactions.
- reg_wr and reg_rd are never both high and never high outside ISSUE.
- Latency, with request first seen in IDLE at cycle 0:
  - Strobe at cycle 1.
  - Write ack at cycle 2.
  - Read ack at cycle 2 + RD_LAT.
- Back-to-back: the next IDLE arbitration happens the cycle after ACK. A requester must drop req at the edge that ends its ack cycle; a req still high in that IDLE cycle is treated as a new request.
- Ungranted master's req and inputs are ignored and may change freely. Its ack stays 0.
- Request withdrawn after grant is a protocol violation: the transaction still completes and the ack still pulses.
- Simultaneous new request and ACK: the request is not lost; it is arbitrated in the following IDLE cycle.
- Reset mid-transaction: the transaction is aborted immediately, no ack is emitted, and a strobe in progress is dropped.
- rdata registers update only on reads and hold across writes.

Optional Feature:
- Macro: UREG_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master's lock = 1 in its ACK cycle, the arbiter is locked to that master: subsequent IDLE cycles grant only that master, and the other req is ignored.
  - Lock releases at the first ACK where the owner's lock = 0, or on reset.
  - Use case: atomic read-modify-write.
- Undefined: lock ports absent; pure round-robin.

Test Plan:
- m0 write addr 0x003, data 0xA5A5_0001 -> reg_wr one cycle at cycle 1 with addr 0x003 and that data; m0_ack at cycle 2; m1_ack stays 0.
- m1 read addr 0x005, RD_LAT = 1, reg_rdata = 0x1234_5678 at cycle 2 -> reg_rd at cycle 1; m1_ack at cycle 3 with m1_rdata = 0x1234_5678.
- m0 and m1 both request from reset, repeatedly -> grant order m0, m1, m0, m1; each ack isolated; never two strobes in one cycle.
- Assert reset during WAIT of a read -> all outputs 0 asynchronously, no ack; after release, a fresh m0 read completes normally with ack at cycle 3.
- RD_LAT = 3, read -> ack at cycle 5; rdata equals the reg_rdata value present at cycle 4.
- UREG_ARB_LOCK_EN defined: m0 reads with lock = 1 while m1_req = 1 -> m0's next write is granted before m1; m1 is granted only after an m0 ACK with lock = 0.
